// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared constants for the UART transmit scheduler: FSM state
//          encoding, byte-source identifiers and the idle line level.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    localparam logic c_src_cpu = 1'b0;
    localparam logic c_src_dbg = 1'b1;

    localparam logic c_idle_level = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_shift.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_shift
// Brief  : Frame shift register with bit-period and bit counters; flags the
//          end of each bit, of the data phase and of the whole frame.
// Rev    : 1.0
// ============================================================================
module uart_tx_shift
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_active,
    input  logic             i_data_phase,
    input  logic             i_stop_phase,
    output logic             o_line,
    output logic             o_bit_done,
    output logic             o_data_done,
    output logic             o_frame_done
);

    localparam int c_baud_w = $clog2(CLKS_PER_BIT + 1);
    localparam int c_bit_w  = $clog2(WIDTH + 1);
    localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(WIDTH - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

    // Start bit sits in bit 0; shifting in idle level leaves the stop level behind
    logic [WIDTH:0]        r_shreg;
    logic [c_baud_w-1:0]   r_baud;
    logic [c_bit_w-1:0]    r_bitcnt;
    logic                  w_bit_done;
    logic                  w_data_done;
    logic                  w_frame_done;

    assign w_bit_done   = i_active && (r_baud == c_baud_max);
    assign w_data_done  = w_bit_done && i_data_phase && (r_bitcnt == c_bit_last);
    assign w_frame_done = w_bit_done && i_stop_phase && (r_bitcnt == c_stop_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= {(WIDTH+1){c_idle_level}};
        end else if (i_load) begin
            r_shreg <= {i_data, 1'b0};
        end else if (w_bit_done) begin
            r_shreg <= {c_idle_level, r_shreg[WIDTH:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud <= '0;
        end else if (i_load) begin
            r_baud <= '0;
        end else if (i_active) begin
            r_baud <= (r_baud == c_baud_max) ? '0 : r_baud + 1'b1;
        end
    end

    // Bit counter indexes data bits, then is reused to count stop bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= '0;
        end else if (i_load) begin
            r_bitcnt <= '0;
        end else if (w_bit_done) begin
            if (w_data_done || w_frame_done) begin
                r_bitcnt <= '0;
            end else if (i_data_phase || i_stop_phase) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    assign o_line       = r_shreg[0];
    assign o_bit_done   = w_bit_done;
    assign o_data_done  = w_data_done;
    assign o_frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_sched
// Brief  : Arbitrates CPU and debug byte sources onto one UART transmit line.
//          Define UART_DBG_EN for the two-source round-robin build; otherwise
//          only the CPU source is served.
// Rev    : 1.0
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_valid,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_ready,
    input  logic             dbg_valid,
    input  logic [WIDTH-1:0] dbg_data,
    output logic             dbg_ready,
    output logic             uart_tx_line,
    output logic             busy
);

    logic [1:0]       r_state;
    logic             w_idle;
    logic             w_accept;
    logic [WIDTH-1:0] w_load_data;
    logic             w_bit_done;
    logic             w_data_done;
    logic             w_frame_done;

    assign w_idle = (r_state == c_st_idle);

`ifdef UART_DBG_EN
    logic r_last_grant;
    logic w_dbg_wins_tie;
    logic w_acc_cpu;
    logic w_acc_dbg;

    assign w_dbg_wins_tie = (r_last_grant == c_src_cpu);
    assign dbg_ready      = w_idle && dbg_valid && (!cpu_valid || w_dbg_wins_tie);
    assign cpu_ready      = w_idle && cpu_valid && !(dbg_valid && w_dbg_wins_tie);
    assign w_acc_cpu      = cpu_valid && cpu_ready;
    assign w_acc_dbg      = dbg_valid && dbg_ready;
    assign w_accept       = w_acc_cpu || w_acc_dbg;
    assign w_load_data    = w_acc_dbg ? dbg_data : cpu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_src_dbg;
        end else if (w_acc_dbg) begin
            r_last_grant <= c_src_dbg;
        end else if (w_acc_cpu) begin
            r_last_grant <= c_src_cpu;
        end
    end
`else
    logic w_unused_dbg;

    assign w_unused_dbg = ^{dbg_valid, dbg_data};
    assign dbg_ready    = 1'b0;
    assign cpu_ready    = w_idle;
    assign w_accept     = cpu_valid && cpu_ready;
    assign w_load_data  = cpu_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (w_accept)     r_state <= c_st_start;
                c_st_start: if (w_bit_done)   r_state <= c_st_data;
                c_st_data:  if (w_data_done)  r_state <= c_st_stop;
                c_st_stop:  if (w_frame_done) r_state <= c_st_idle;
                default:                      r_state <= c_st_idle;
            endcase
        end
    end

    uart_tx_shift #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_data       (w_load_data),
        .i_active     (!w_idle),
        .i_data_phase (r_state == c_st_data),
        .i_stop_phase (r_state == c_st_stop),
        .o_line       (uart_tx_line),
        .o_bit_done   (w_bit_done),
        .o_data_done  (w_data_done),
        .o_frame_done (w_frame_done)
    );

    assign busy = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_sched
// Brief  : Self-checking bench for uart_tx_sched (default timing instance and
//          a CLKS_PER_BIT=1 / STOP_BITS=2 instance).
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_valid, dbg_valid;
    logic [7:0] cpu_data, dbg_data;
    logic       cpu_ready, dbg_ready, tx_line, busy;

    logic       cpu_valid2;
    logic [7:0] cpu_data2;
    logic       cpu_ready2, dbg_ready2, tx_line2, busy2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit m_last_dbg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    uart_tx_sched dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid),
        .cpu_data     (cpu_data),
        .cpu_ready    (cpu_ready),
        .dbg_valid    (dbg_valid),
        .dbg_data     (dbg_data),
        .dbg_ready    (dbg_ready),
        .uart_tx_line (tx_line),
        .busy         (busy)
    );

    uart_tx_sched #(.WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .cpu_valid    (cpu_valid2),
        .cpu_data     (cpu_data2),
        .cpu_ready    (cpu_ready2),
        .dbg_valid    (1'b0),
        .dbg_data     (8'h00),
        .dbg_ready    (dbg_ready2),
        .uart_tx_line (tx_line2),
        .busy         (busy2)
    );

    // Expected line level for cycle N+1+t after acceptance in cycle N
    function automatic logic [63:0] frame_bits(input logic [7:0] d, input int cpb, input int sb);
        logic [63:0] v;
        int idx;
        v = '0;
        for (int t = 0; t < (9 + sb) * cpb; t++) begin
            idx = t / cpb;
            if (idx == 0)      v[t] = 1'b0;
            else if (idx <= 8) v[t] = d[idx-1];
            else               v[t] = 1'b1;
        end
        return v;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_valid = 1'b0; dbg_valid = 1'b0; cpu_valid2 = 1'b0;
        drive_edge();
        drive_edge();
        rst = 1'b0;
        m_last_dbg = 1'b1;
    endtask

    task automatic wait_accept(input bit want_dbg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (want_dbg ? (dbg_valid && dbg_ready) : (cpu_valid && cpu_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout src_dbg=%0d got=no_acceptance required=acceptance", want_dbg);
        end
    endtask

    // Called just after the edge that accepted byte d (DUT now in cycle N+1)
    task automatic run_frame(input logic [7:0] d, input string name);
        logic [63:0] got, bz, exp, mask;
        logic rdy_seen;
        got = '0; bz = '0; rdy_seen = 1'b0;
        exp  = frame_bits(d, 2, 1);
        mask = (64'd1 << 20) - 64'd1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            got[t] = tx_line;
            bz[t]  = busy;
            rdy_seen = rdy_seen | cpu_ready | dbg_ready;
        end
        @(negedge clk);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_line data=%h got=%h required=%h", name, d, got[19:0], exp[19:0]);
        end
        checks++;
        if (bz !== mask || busy !== 1'b0 || tx_line !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy got=%h/%b/%b required=%h/0/1", name, bz[19:0], busy, tx_line, mask[19:0]);
        end
        checks++;
        if (rdy_seen !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_in_frame got=%b required=0", name, rdy_seen);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0 || tx_line2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b required=1010", tx_line, busy, tx_line2, busy2);
        end
        cpu_valid = 1'b1;
        #1;
        checks++;
        if (cpu_ready !== 1'b1 || dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpu_ready got=%b%b required=10", cpu_ready, dbg_ready);
        end
        cpu_valid = 1'b0; dbg_valid = 1'b1;
        #1;
        checks++;
`ifdef UART_DBG_EN
        if (dbg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_dbg_ready got=%b required=1", dbg_ready);
        end
`else
        if (dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_dbg_ready got=%b required=0", dbg_ready);
        end
`endif
        dbg_valid = 1'b0;
    endtask

    task automatic test_cpu_single();
        bit ok;
        drive_edge();
        cpu_valid = 1'b1; cpu_data = 8'h01;
        wait_accept(1'b0, ok);
        m_last_dbg = 1'b0;
        drive_edge();
        cpu_valid = 1'b0; cpu_data = 8'($urandom);
        run_frame(8'h01, "cpu_single");
    endtask

    task automatic test_arbitration();
        bit ok;
`ifdef UART_DBG_EN
        do_reset();
        cpu_valid = 1'b1; cpu_data = 8'hA5;
        dbg_valid = 1'b1; dbg_data = 8'h3C;
        #1;
        checks++;
        if ({cpu_ready, dbg_ready} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first got=%b required=10", {cpu_ready, dbg_ready});
        end
        wait_accept(1'b0, ok);
        drive_edge();
        cpu_valid = 1'b0; cpu_data = 8'h00;
        run_frame(8'hA5, "tie_cpu");
        wait_accept(1'b1, ok);
        drive_edge();
        dbg_data = 8'h00;
        cpu_valid = 1'b1; cpu_data = 8'hC3;
        run_frame(8'h3C, "tie_dbg");
        checks++;
        if ({cpu_ready, dbg_ready} !== 2'b10) begin
            failures++;
            $display("FAIL tie_second got=%b required=10", {cpu_ready, dbg_ready});
        end
        wait_accept(1'b0, ok);
        drive_edge();
        cpu_valid = 1'b0; dbg_valid = 1'b0;
        run_frame(8'hC3, "tie_cpu2");
        m_last_dbg = 1'b0;
`else
        bit seen;
        drive_edge();
        dbg_valid = 1'b1; dbg_data = 8'hEE;
        cpu_valid = 1'b1; cpu_data = 8'h12;
        #1;
        checks++;
        if (dbg_ready !== 1'b0) begin
            failures++;
            $display("FAIL nodbg_ready got=%b required=0", dbg_ready);
        end
        wait_accept(1'b0, ok);
        drive_edge();
        cpu_valid = 1'b0;
        run_frame(8'h12, "nodbg_cpu");
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | dbg_ready | busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL nodbg_idle got=%b required=0", seen);
        end
        dbg_valid = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        bit ok;
        int prev;
        logic [7:0] d;
        prev = 0;
        drive_edge();
        cpu_valid = 1'b1; cpu_data = 8'h01;
        for (int i = 0; i < 8; i++) begin
            wait_accept(1'b0, ok);
            if (!ok) break;
            if (i > 0) begin
                checks++;
                if (cyc - prev !== 21) begin
                    failures++;
                    $display("FAIL b2b_spacing got=%0d required=21", cyc - prev);
                end
            end
            prev = cyc;
            d = cpu_data;
            drive_edge();
            if (i < 7) cpu_data = d << 1;
            else       cpu_valid = 1'b0;
            run_frame(d, "b2b");
        end
        m_last_dbg = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        drive_edge();
        cpu_valid = 1'b1; cpu_data = 8'hFF;
        wait_accept(1'b0, ok);
        drive_edge();
        cpu_valid = 1'b0; cpu_data = 8'h00;
        repeat (11) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tx_line !== 1'b1) begin
            failures++;
            $display("FAIL mid_before got=%b%b required=11", busy, tx_line);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_line !== 1'b1) begin
            failures++;
            $display("FAIL mid_async got=%b%b required=01", busy, tx_line);
        end
        drive_edge();
        rst = 1'b0;
        m_last_dbg = 1'b1;
        cpu_valid = 1'b1; cpu_data = 8'h55;
        wait_accept(1'b0, ok);
        drive_edge();
        cpu_valid = 1'b0;
        run_frame(8'h55, "after_reset");
        m_last_dbg = 1'b0;
    endtask

    task automatic test_random();
        bit ok, cv, dv, win_dbg;
        logic [1:0] r;
        logic [7:0] cd, dd;
        for (int n = 0; n < 8; n++) begin
`ifdef UART_DBG_EN
            r = 2'($urandom_range(1, 3));
            cv = r[0]; dv = r[1];
            win_dbg = dv && (!cv || !m_last_dbg);
`else
            cv = 1'b1; dv = 1'($urandom_range(0, 1));
            win_dbg = 1'b0;
`endif
            cd = 8'($urandom); dd = 8'($urandom);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            cpu_valid = cv; cpu_data = cd;
            dbg_valid = dv; dbg_data = dd;
            #1;
            checks++;
            if ({cpu_ready, dbg_ready} !== {!win_dbg, win_dbg}) begin
                failures++;
                $display("FAIL rand_grant cv=%b dv=%b got=%b required=%b", cv, dv,
                         {cpu_ready, dbg_ready}, {!win_dbg, win_dbg});
            end
            wait_accept(win_dbg, ok);
            m_last_dbg = win_dbg;
            drive_edge();
            cpu_valid = 1'b0; dbg_valid = 1'b0;
            cpu_data = 8'($urandom); dbg_data = 8'($urandom);
            run_frame(win_dbg ? dd : cd, "rand");
        end
    endtask

    task automatic test_fast();
        logic [63:0] got, bz, exp;
        logic [7:0] d;
        bit ok;
        for (int n = 0; n < 2; n++) begin
            d = (n == 0) ? 8'h80 : 8'($urandom);
            drive_edge();
            cpu_valid2 = 1'b1; cpu_data2 = d;
            ok = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (cpu_ready2) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL fast_accept got=no_acceptance required=acceptance");
            end
            drive_edge();
            cpu_valid2 = 1'b0; cpu_data2 = 8'h00;
            got = '0; bz = '0;
            exp = frame_bits(d, 1, 2);
            for (int t = 0; t < 11; t++) begin
                @(negedge clk);
                got[t] = tx_line2;
                bz[t]  = busy2;
            end
            @(negedge clk);
            checks++;
            if (got[10:0] !== exp[10:0]) begin
                failures++;
                $display("FAIL fast_line data=%h got=%h required=%h", d, got[10:0], exp[10:0]);
            end
            checks++;
            if (bz[10:0] !== 11'h7FF || busy2 !== 1'b0 || tx_line2 !== 1'b1) begin
                failures++;
                $display("FAIL fast_busy got=%h/%b/%b required=7ff/0/1", bz[10:0], busy2, tx_line2);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        cpu_valid = 1'b0; dbg_valid = 1'b0; cpu_valid2 = 1'b0;
        cpu_data = 8'h00; dbg_data = 8'h00; cpu_data2 = 8'h00;
        m_last_dbg = 1'b1;
        test_reset();
        test_cpu_single();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_fast();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
